imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: accepts a byte stream from a

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/imem_loader_packer.sv | 30 +++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory side of the core:
// memory geometry and the program-loader state encoding.
package riscv_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_LOAD  = 2'd1,
    LDR_WRITE = 2'd2,
    LDR_DONE  = 2'd3
  } loader_state_e;

  // Plain vector constants so the FSM register stays a simple logic [1:0].
  localparam logic [1:0] ST_IDLE  = 2'(LDR_IDLE);
  localparam logic [1:0] ST_LOAD  = 2'(LDR_LOAD);
  localparam logic [1:0] ST_WRITE = 2'(LDR_WRITE);
  localparam logic [1:0] ST_DONE  = 2'(LDR_DONE);

endpackage

// File: rtl/imem_loader_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; byte k lands in
// bits [8k+7:8k], and word_ready marks the transfer of byte 3.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  assign word_ready = byte_valid & (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (byte_valid) begin
      word[{byte_cnt, 3'b000} +: 8] <= byte_in;
      byte_cnt                      <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a host byte link into instruction memory, one 32-bit word at a time
// from word 0 upward, holding the core in busy until the load finishes.
//
// Byte link handshake: a byte transfers on a rising edge where in_valid and
// in_ready are both 1; in_ready depends on the loader state alone, and the
// host may hold in_valid low for any number of cycles between bytes.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W:0]   num_reg;
  logic              done_r;
  logic              err_r;

  logic              idle_like;
  logic              start_ok;
  logic              start_load;
  logic              fire;
  logic              word_ready;
  logic              last_word;
  logic [31:0]       packed_word;

  assign idle_like  = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok   = start && idle_like;
  assign start_load = start_ok && (num_words != '0) && (num_words <= DEPTH_V);
  assign fire       = in_valid && in_ready;
  assign last_word  = ({1'b0, word_idx} == (num_reg - ONE_V));

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_load),
    .byte_valid (fire),
    .byte_in    (in_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      num_reg  <= '0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            if (num_words == '0) begin
              state  <= ST_DONE;
              done_r <= 1'b1;
              err_r  <= 1'b0;
            end else if (num_words > DEPTH_V) begin
              state  <= ST_IDLE;
              done_r <= 1'b0;
              err_r  <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              word_idx <= '0;
              num_reg  <= num_words;
              done_r   <= 1'b0;
              err_r    <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (word_ready) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // num_reg never exceeds DEPTH, so word_idx stops at DEPTH-1.
          if (last_word) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_LOAD);
  assign mem_we    = (state == ST_WRITE);
  assign mem_addr  = mem_we ? word_idx : '0;
  assign mem_wdata = mem_we ? DATA_W'(packed_word) : '0;
  assign busy      = (state == ST_LOAD) || (state == ST_WRITE);
  assign done      = done_r;
  assign err       = err_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected memory writes plus
// per-cycle output rules and hand-computed literal expectations.
module tb_imem_loader;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [5:0]  exp_addr_q[$];
  int          next_addr = 0;
  int          writes_seen = 0;
  int          we_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle out of reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy_is_load_or_write", {31'd0, busy}, {31'd0, in_ready | mem_we});
      check("no_ready_during_write", {31'd0, in_ready & mem_we}, 32'd0);
      check("done_not_busy", {31'd0, done & busy}, 32'd0);
      if (mem_we === 1'b1) begin
        writes_seen++;
        we_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=addr %0d data %0h required=no write", mem_addr, mem_wdata);
        end else begin
          check("write_addr", {26'd0, mem_addr}, {26'd0, exp_addr_q.pop_front()});
          check("write_data", mem_wdata, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks (entered and left at a falling edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int bound;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    bound = 0;
    while (in_ready !== 1'b1 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=no in_ready required=in_ready within 200 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    exp_q.push_back(w);
    exp_addr_q.push_back(6'(next_addr));
    next_addr++;
    for (int k = 0; k < 4; k++) begin
      send_byte(8'((w >> (8 * k)) & 32'hFF), (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = 7'(n);
    next_addr = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_state_idle"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=still running required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w_before;
    rst_n = 1'b0; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);

    // 1: reset state
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 2: single word 0x00000013, back-to-back bytes
    do_start(1);
    send_word(32'h0000_0013, 0);
    check("t2_we", {31'd0, mem_we}, 32'd1);
    check("t2_addr", {26'd0, mem_addr}, 32'd0);
    check("t2_data", mem_wdata, 32'h0000_0013);
    check("t2_done_before", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_writes", writes_seen, 32'd1);

    // 3: full memory with random gaps
    do_start(64);
    for (int i = 0; i < 64; i++) send_word(32'hA5A5_0000 + 32'(i), 3);
    check("t3_last_addr", {26'd0, mem_addr}, 32'd63);
    check("t3_last_data", mem_wdata, 32'hA5A5_003F);
    @(negedge clk);
    check("t3_done", {31'd0, done}, 32'd1);
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("t3_writes", writes_seen, 32'd65);
    check("t3_queue_empty", exp_q.size(), 32'd0);

    // 4: zero words then oversize request
    w_before = writes_seen;
    do_start(0);
    check("t4_zero_done", {31'd0, done}, 32'd1);
    check("t4_zero_busy", {31'd0, busy}, 32'd0);
    check("t4_zero_err", {31'd0, err}, 32'd0);
    do_start(65);
    check("t4_big_err", {31'd0, err}, 32'd1);
    check("t4_big_done", {31'd0, done}, 32'd0);
    check("t4_big_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_big_ready_held", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    check("t4_no_writes", writes_seen - w_before, 32'd0);

    // 5: ignored start mid-load, then reset mid-word
    do_start(4);
    check("t5_err_cleared", {31'd0, err}, 32'd0);
    send_word(32'h1111_2222, 1);
    send_word(32'h3333_4444, 1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    start = 1'b1; num_words = 7'd1;
    @(negedge clk);
    start = 1'b0;
    check("t5_still_busy", {31'd0, busy}, 32'd1);
    check("t5_still_ready", {31'd0, in_ready}, 32'd1);
    check("t5_no_done", {31'd0, done}, 32'd0);
    check("t5_queue_empty", exp_q.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1);
    send_word(32'hCAFE_0001, 0);
    check("t5_addr_zero", {26'd0, mem_addr}, 32'd0);
    @(negedge clk);
    check("t5_done", {31'd0, done}, 32'd1);

    // 6: continuous stream, one write per 5 cycles
    do_start(8);
    we_cyc.delete();
    for (int i = 0; i < 8; i++) send_word(32'hDEAD_BEEF ^ (32'h0101_0101 * 32'(i)), 0);
    check("t6_we_last", {31'd0, mem_we}, 32'd1);
    check("t6_addr_last", {26'd0, mem_addr}, 32'd7);
    check("t6_done_before", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_we_count", we_cyc.size(), 32'd8);
    for (int i = 1; i < we_cyc.size(); i++)
      check("t6_write_spacing", we_cyc[i] - we_cyc[i-1], 32'd5);

    repeat (3) @(negedge clk);
    check("total_writes", writes_seen, 32'd76);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
